// File: rtl/packet_fold_pkg.sv
// Shared types and helpers for the packet fold-add datapath.
// Optional macro PACKET_FOLD_SAT_EN: when defined, fold additions saturate
// at the maximum unsigned value instead of wrapping.
package packet_fold_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam int NBANK = 2;

    // Widest data word the helper below can handle; callers zero-extend into it.
    localparam int MAXDW = 64;

    // Adds two dw-bit words held in MAXDW-bit containers; the caller truncates
    // the result back to dw bits. Wraps by default, saturates when enabled.
    function automatic logic [MAXDW-1:0] fold_add(input logic [MAXDW-1:0] a,
                                                   input logic [MAXDW-1:0] b,
                                                   input int dw);
        logic [MAXDW:0] sum;
        logic [MAXDW:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{MAXDW{1'b0}}, 1'b1} << dw) - 1'b1;
`ifdef PACKET_FOLD_SAT_EN
        return (sum > lim) ? lim[MAXDW-1:0] : sum[MAXDW-1:0];
`else
        return sum[MAXDW-1:0] & lim[MAXDW-1:0];
`endif
    endfunction

endpackage

// File: rtl/packet_fold_bank.sv
// One packet buffer bank: word storage, captured length and fold length,
// the bank lifecycle state, and two combinational read ports so the head
// word and its fold partner can be fetched in the same cycle.
module packet_fold_bank
    import packet_fold_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int KW    = $clog2(DEPTH + 1),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic          i_wr_store,
    input  logic          i_wr_last,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [KW-1:0] i_wr_k,
    input  logic [KW-1:0] i_wr_len,
    input  logic          i_rd_start,
    input  logic          i_rd_done,
    input  logic [AW-1:0] i_head_addr,
    input  logic [AW-1:0] i_tail_addr,
    output logic [DW-1:0] o_head_data,
    output logic [DW-1:0] o_tail_data,
    output bank_state_e   o_state,
    output logic [KW-1:0] o_len,
    output logic [KW-1:0] o_k
);

    logic [DW-1:0] r_mem [DEPTH];
    bank_state_e   r_state;
    logic [KW-1:0] r_len;
    logic [KW-1:0] r_k;

    // Word storage; beats beyond the bank capacity are never stored.
    always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_store) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Bank lifecycle; the writer only touches EMPTY/FILLING banks and the
    // reader only FULL/DRAINING ones, so the requests never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_len   <= '0;
            r_k     <= '0;
        end else begin
            if (i_rd_done) begin
                r_state <= EMPTY;
            end else if (i_rd_start) begin
                r_state <= DRAINING;
            end else if (i_wr_en) begin
                if (i_wr_last) begin
                    r_state <= FULL;
                    r_len   <= i_wr_len;
                end else if (r_state == EMPTY) begin
                    r_state <= FILLING;
                end
                if (r_state == EMPTY) begin
                    r_k <= i_wr_k;
                end
            end
        end
    end

    assign o_head_data = r_mem[i_head_addr];
    assign o_tail_data = r_mem[i_tail_addr];
    assign o_state     = r_state;
    assign o_len       = r_len;
    assign o_k         = r_k;

endmodule

// File: rtl/packet_fold_add.sv
// Store-and-forward AXI-Stream packet folder with two ping-pong banks.
// A packet is buffered whole, then emitted with its last K words added onto
// its first K words. Define PACKET_FOLD_SAT_EN for saturating additions.
module packet_fold_add
    import packet_fold_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    parameter int KW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [KW-1:0] cfg_k,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          ovf
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [KW-1:0] DEPTH_K = KW'(DEPTH);

    // Bank-facing signals
    bank_state_e      w_state [NBANK];
    logic [KW-1:0]    w_len   [NBANK];
    logic [KW-1:0]    w_k     [NBANK];
    logic [DW-1:0]    w_head  [NBANK];
    logic [DW-1:0]    w_tail  [NBANK];
    logic [NBANK-1:0] w_wr_en;
    logic [NBANK-1:0] w_rd_start;
    logic [NBANK-1:0] w_rd_done;

    // Write side
    logic          r_run;
    logic          r_wr_ptr;
    logic [KW-1:0] r_wr_idx;
    logic          r_ovf;
    bank_state_e   w_wr_state;
    logic          w_s_hs;
    logic          w_in_range;
    logic [KW-1:0] w_wr_len;

    // Read side
    logic          r_rd_ptr;
    logic [KW-1:0] r_rd_idx;
    logic [DW-1:0] r_m_tdata;
    logic          r_m_tvalid;
    logic          r_m_tlast;
    logic          w_m_hs;
    logic          w_last_hs;
    logic          w_src;
    logic [KW-1:0] w_rd_idx;
    bank_state_e   w_src_state;
    logic [KW-1:0] w_src_len;
    logic [KW-1:0] w_src_k;
    logic [KW-1:0] w_keff;
    logic [AW-1:0] w_head_addr;
    logic [AW-1:0] w_tail_addr;
    logic [DW-1:0] w_fold;
    logic          w_load;

    assign w_wr_state = w_state[r_wr_ptr];
    assign s_tready   = r_run && ((w_wr_state == EMPTY) || (w_wr_state == FILLING));
    assign w_s_hs     = s_tvalid && s_tready;
    assign w_in_range = (r_wr_idx < DEPTH_K);
    assign w_wr_len   = w_in_range ? (r_wr_idx + KW'(1)) : DEPTH_K;

    // When the last output beat leaves, the reader moves to the other bank in
    // the same cycle so a waiting packet follows without a bubble.
    assign w_m_hs      = r_m_tvalid && m_tready;
    assign w_last_hs   = w_m_hs && r_m_tlast;
    assign w_src       = w_last_hs ? ~r_rd_ptr : r_rd_ptr;
    assign w_rd_idx    = w_last_hs ? '0 : r_rd_idx;
    assign w_src_state = w_state[w_src];
    assign w_src_len   = w_len[w_src];
    assign w_src_k     = w_k[w_src];
    assign w_keff      = (w_src_k < w_src_len) ? w_src_k : w_src_len;
    assign w_head_addr = AW'(w_rd_idx);
    assign w_tail_addr = AW'(w_src_len - w_keff + w_rd_idx);
    assign w_fold      = DW'(fold_add(MAXDW'(w_head[w_src]), MAXDW'(w_tail[w_src]), DW));
    assign w_load      = (!r_m_tvalid || m_tready) &&
                         ((w_src_state == FULL) ||
                          ((w_src_state == DRAINING) && (w_rd_idx < w_src_len)));

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign w_wr_en[b]    = w_s_hs && (r_wr_ptr == 1'(b));
        assign w_rd_start[b] = w_load && (w_src_state == FULL) && (w_src == 1'(b));
        assign w_rd_done[b]  = w_last_hs && (r_rd_ptr == 1'(b));

        packet_fold_bank #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .KW    (KW),
            .AW    (AW)
        ) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_wr_en     (w_wr_en[b]),
            .i_wr_store  (w_in_range),
            .i_wr_last   (s_tlast),
            .i_wr_addr   (AW'(r_wr_idx)),
            .i_wr_data   (s_tdata),
            .i_wr_k      (cfg_k),
            .i_wr_len    (w_wr_len),
            .i_rd_start  (w_rd_start[b]),
            .i_rd_done   (w_rd_done[b]),
            .i_head_addr (w_head_addr),
            .i_tail_addr (w_tail_addr),
            .o_head_data (w_head[b]),
            .o_tail_data (w_tail[b]),
            .o_state     (w_state[b]),
            .o_len       (w_len[b]),
            .o_k         (w_k[b])
        );
    end

    // Write pointer and index; oversize packets keep being accepted but the
    // index parks at DEPTH so the excess beats are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_wr_idx <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_ovf <= w_s_hs && s_tlast && !w_in_range;
            if (w_s_hs) begin
                if (s_tlast) begin
                    r_wr_idx <= '0;
                    r_wr_ptr <= ~r_wr_ptr;
                end else if (w_in_range) begin
                    r_wr_idx <= r_wr_idx + KW'(1);
                end
            end
        end
    end

    // Registered output stage; it only advances when empty or consumed, so a
    // stalled sink sees every m_* signal frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr   <= 1'b0;
            r_rd_idx   <= '0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else begin
            if (w_last_hs) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_load) begin
                r_m_tdata  <= (w_rd_idx < w_keff) ? w_fold : w_head[w_src];
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= (w_rd_idx == (w_src_len - KW'(1)));
                r_rd_idx   <= w_rd_idx + KW'(1);
            end else begin
                if (w_m_hs) begin
                    r_m_tvalid <= 1'b0;
                end
                if (w_last_hs) begin
                    r_rd_idx <= '0;
                end
            end
        end
    end

    assign m_tdata  = r_m_tdata;
    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_packet_fold_add.sv
// Scoreboard bench for packet_fold_add: a driver pushes the expected output
// of each completed packet, a forked monitor pops and compares on every
// output handshake. Expected data comes from constants or a simple fold model.
module tb_packet_fold_add;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int KW    = $clog2(DEPTH + 1);
    localparam int MAXV  = (1 << DW) - 1;

    typedef int intq_t[$];
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KW-1:0] cfg_k;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          ovf;

    int    vectors       = 0;
    int    miscompares   = 0;
    int    cyc           = 0;
    int    firstValidCyc = -1;
    int    firstHsCyc    = 0;
    int    lastHsCyc     = 0;
    int    ovfExpCyc     = -10;
    bit    logEn         = 1'b0;
    bit    readyRandom   = 1'b0;
    exp_t  expQ[$];
    int    hsLog[$];

    packet_fold_add #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .KW    (KW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_k    (cfg_k),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Folded output of a packet from its first min(len,DEPTH) words.
    task automatic refFold(input intq_t pkt, input int k, output intq_t res);
        int len;
        int keff;
        int v;
        res.delete();
        len  = (pkt.size() > DEPTH) ? DEPTH : pkt.size();
        keff = (k < len) ? k : len;
        for (int i = 0; i < len; i++) begin
            v = pkt[i];
            if (i < keff) begin
                v = pkt[i] + pkt[len - keff + i];
`ifdef PACKET_FOLD_SAT_EN
                if (v > MAXV) v = MAXV;
`else
                v = v % (MAXV + 1);
`endif
            end
            res.push_back(v);
        end
    endtask

    task automatic applyStimulus(input intq_t pkt, input int k, input intq_t expData,
                                 input int gapPct, input int stopAfter);
        int   n;
        int   budget;
        int   hsCyc;
        bit   accepted;
        exp_t e;
        n     = (stopAfter < 0) ? pkt.size() : stopAfter;
        hsCyc = 0;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gapPct) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = DW'(pkt[i]);
            s_tlast  = (stopAfter < 0) && (i == pkt.size() - 1);
            cfg_k    = (i == 0) ? KW'(k) : KW'($urandom_range(0, 15));
            accepted = 1'b0;
            budget   = 0;
            while (!accepted && budget < 500) begin
                @(negedge clk);
                accepted = s_tready;
                hsCyc    = cyc;
                budget++;
                @(posedge clk);
                #1;
            end
            if (!accepted) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL input_handshake: s_tready stuck low, got 0, expected 1");
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
            if (i == 0) firstHsCyc = hsCyc;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (stopAfter < 0) begin
            lastHsCyc = hsCyc;
            if (pkt.size() > DEPTH) ovfExpCyc = hsCyc + 1;
            for (int j = 0; j < expData.size(); j++) begin
                e.data = DW'(expData[j]);
                e.last = (j == expData.size() - 1);
                expQ.push_back(e);
            end
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while ((expQ.size() != 0 || m_tvalid) && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 5000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d beats still pending, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic randomPackets(input int count, input int gapPct);
        intq_t pkt;
        intq_t res;
        int    len;
        int    k;
        for (int p = 0; p < count; p++) begin
            len = $urandom_range(1, DEPTH + 3);
            k   = $urandom_range(0, DEPTH + 3);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(int'($urandom_range(0, MAXV)));
            refFold(pkt, k, res);
            applyStimulus(pkt, k, res, gapPct, -1);
        end
    endtask

    task automatic runMonitor();
        logic          prevHold;
        logic [DW-1:0] prevData;
        logic          prevLast;
        exp_t          e;
        prevHold = 1'b0;
        prevData = '0;
        prevLast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevHold = 1'b0;
                continue;
            end
            if (cyc == ovfExpCyc || ovf) begin
                checkOutput("ovf_pulse", int'(ovf), int'(cyc == ovfExpCyc));
            end
            if (prevHold) begin
                checkOutput("hold_tvalid", int'(m_tvalid), 1);
                checkOutput("hold_tdata", int'(m_tdata), int'(prevData));
                checkOutput("hold_tlast", int'(m_tlast), int'(prevLast));
            end
            if (m_tvalid && firstValidCyc < 0) firstValidCyc = cyc;
            if (m_tvalid && m_tready) begin
                if (logEn) hsLog.push_back(cyc);
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_beat: got data %0d, expected no output", m_tdata);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("m_tdata", int'(m_tdata), int'(e.data));
                    checkOutput("m_tlast", int'(m_tlast), int'(e.last));
                end
            end
            prevHold = m_tvalid && !m_tready;
            prevData = m_tdata;
            prevLast = m_tlast;
        end
    endtask

    task automatic runReady();
        forever begin
            @(posedge clk);
            #1;
            m_tready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    initial begin
        intq_t pkt;
        intq_t expd;
        int    aFirst;

        rst_n    = 1'b0;
        cfg_k    = '0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_tready", int'(s_tready), 0);
        checkOutput("rst_m_tvalid", int'(m_tvalid), 0);
        checkOutput("rst_m_tlast", int'(m_tlast), 0);
        checkOutput("rst_m_tdata", int'(m_tdata), 0);
        checkOutput("rst_ovf", int'(ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fork
            runMonitor();
            runReady();
        join_none

        // Basic fold with latency check
        firstValidCyc = -1;
        pkt  = '{1, 2, 3, 4, 5};
        expd = '{5, 7, 3, 4, 5};
        applyStimulus(pkt, 2, expd, 0, -1);
        waitDrain();
        checkOutput("latency", firstValidCyc - lastHsCyc, 2);

        // Pass-through, K beyond length, wrap, single beat
        pkt  = '{10, 20, 30};
        expd = '{10, 20, 30};
        applyStimulus(pkt, 0, expd, 0, -1);
        pkt  = '{1, 2, 3};
        expd = '{2, 4, 6};
        applyStimulus(pkt, 5, expd, 0, -1);
        pkt  = '{200, 0, 100};
`ifdef PACKET_FOLD_SAT_EN
        expd = '{255, 0, 100};
`else
        expd = '{44, 0, 100};
`endif
        applyStimulus(pkt, 1, expd, 0, -1);
        pkt  = '{77};
        expd = '{154};
        applyStimulus(pkt, 1, expd, 0, -1);
        waitDrain();

        // Ping-pong: three back-to-back packets with the sink always ready
        readyRandom = 1'b0;
        hsLog.delete();
        logEn = 1'b1;
        for (int p = 0; p < 3; p++) begin
            pkt.delete();
            for (int i = 0; i < 4; i++) pkt.push_back(int'($urandom_range(0, MAXV)));
            refFold(pkt, p + 1, expd);
            applyStimulus(pkt, p + 1, expd, 0, -1);
            if (p == 0) aFirst = firstHsCyc;
        end
        waitDrain();
        logEn = 1'b0;
        checkOutput("write_span", lastHsCyc - aFirst, 12);
        checkOutput("pingpong_beats", hsLog.size(), 12);
        if (hsLog.size() >= 5) checkOutput("bubble_gap", hsLog[4] - hsLog[3], 1);

        // Backpressure on the basic packet
        readyRandom = 1'b1;
        pkt  = '{1, 2, 3, 4, 5};
        expd = '{5, 7, 3, 4, 5};
        applyStimulus(pkt, 2, expd, 0, -1);
        waitDrain();

        // Overflow: 10 words into an 8-word bank
        pkt  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        expd = '{9, 2, 3, 4, 5, 6, 7, 8};
        applyStimulus(pkt, 1, expd, 0, -1);
        waitDrain();

        // Reset mid-packet discards the partial packet
        readyRandom = 1'b0;
        pkt  = '{11, 22, 33, 44, 55};
        expd = '{11, 22, 33, 44, 55};
        applyStimulus(pkt, 0, expd, 0, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst_s_tready", int'(s_tready), 0);
        checkOutput("midrst_m_tvalid", int'(m_tvalid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_s_tready", int'(s_tready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("after_rst_s_tready", int'(s_tready), 1);
        repeat (10) @(posedge clk);
        #1;
        pkt  = '{3, 6, 9};
        expd = '{12, 6, 9};
        applyStimulus(pkt, 1, expd, 0, -1);
        waitDrain();

        // Random traffic, with and without sink backpressure
        readyRandom = 1'b1;
        randomPackets(40, 25);
        waitDrain();
        readyRandom = 1'b0;
        randomPackets(20, 0);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packet_fold_add.md
Name: packet_fold_add

Overview:
Parametrised successor to the single-buffer packet adder. It is a store-and-forward AXI-Stream block that buffers a complete packet, then emits it with the last K words folded (added) onto the first K words. It uses two ping-pong banks, so one packet can be received while the previous one drains. It has full backpressure on both sides and sits inline between a stream source and sink in the packet datapath.

Parameters:
DW, 8, data width in bits
DEPTH, 64, max words per packet per bank; must be a power of two and at least 2
KW, $clog2(DEPTH+1), width of the fold-length config and internal length counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_k  in  KW  fold length K; sampled on the first accepted beat of each packet
s_tdata  in  DW  input data
s_tvalid  in  1  input valid
s_tlast  in  1  input end of packet
s_tready  out  1  input ready
m_tdata  out  DW  output data
m_tvalid  out  1  output valid
m_tlast  out  1  output end of packet
m_tready  in  1  output ready
ovf  out  1  one-cycle pulse: packet exceeded DEPTH and was truncated

Behaviour:
- Reset: one clock, synchronous, active-low; rst_n low on a rising edge of clk resets the block.
  - Reset values: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, ovf=0.
  - Both banks go EMPTY and the write and read bank pointers go to 0.
  - s_tready rises on the first cycle after rst_n is seen high.
  - Reset mid-packet discards all buffered and partially received data. No partial packet is ever emitted.
- Bank states: EMPTY -> FILLING (first beat accepted) -> FULL (tlast accepted) -> DRAINING (first output beat loaded) -> EMPTY (last output beat handshaken).
- Write side:
  - s_tready = 1 when the current write bank is EMPTY or FILLING.
  - On each handshake, the word is stored at wr_idx and wr_idx increments.
  - On the first beat, cfg_k is latched into the bank.
  - On tlast, the bank stores len = wr_idx+1, goes FULL, and the write pointer toggles to the other bank.
- Overflow:
  - Beats at wr_idx >= DEPTH are accepted (s_tready stays 1) but discarded.
  - len is capped at DEPTH.
  - ovf pulses for one cycle on the tlast handshake of such a packet.
- Fold arithmetic, with Keff = min(K, len):
  - for i < Keff: out[i] = mem[i] + mem[len-Keff+i], DW-bit wrap-around (carry dropped)
  - for i >= Keff: out[i] = mem[i]
  - K=0 is pure pass-through.
  - K>=len gives out[i] = 2*mem[i] mod 2^DW.
  - Output length is always len; m_tlast is asserted on i = len-1.
- Read side:
  - The output register loads when (!m_tvalid || m_tready) and the read bank is FULL or DRAINING with words remaining.
  - m_tdata, m_tvalid and m_tlast are registered; no combinational path from m_tready to m_tdata.
  - Holding m_tready low freezes all m_* outputs unchanged.
  - After the last-beat handshake the bank goes EMPTY, the read pointer toggles, and the next FULL bank loads in the same cycle. This gives back-to-back packets with no bubble.
- Latency: with the reader idle, a tlast handshake at cycle T gives the first m_tvalid at T+2.
- Throughput: 1 word/cycle sustained when the two sides are balanced.
- Simultaneous events:
  - A bank freed by the reader in the same cycle the writer wants it is usable by the writer on the next cycle.
  - A single-beat packet (tvalid and tlast on the first beat) is legal; len=1.
  - With both banks FULL, s_tready=0.

Optional Feature:
PACKET_FOLD_SAT_EN
- Defined: fold additions saturate, unsigned, at 2^DW-1 instead of wrapping.
- Undefined: modulo-2^DW wrap, with no extra logic.
- Pass-through words (i >= Keff) are unaffected either way.

Decomposition:
- Package packet_fold_pkg holds:
  - the bank_state_e enum (EMPTY, FILLING, FULL, DRAINING)
  - localparam NBANK=2
  - function fold_add(a, b): wrap or saturate, selected by the macro
- Sub-module packet_fold_bank holds, for one bank:
  - the storage array
  - the len and k registers
  - the state register
  - two asynchronous read ports (head index, tail index)
- The top instantiates two banks plus the write and read control.

Test Plan:
1. DW=8, K=2, packet 1,2,3,4,5 -> output 5,7,3,4,5, tlast on 5th beat, first m_tvalid 2 cycles after input tlast.
2. K=0, packet 10,20,30 -> 10,20,30 unchanged. K=5 on len=3 packet 1,2,3 -> 2,4,6.
3. Wrap: K=1, packet 200,0,100 -> 44,0,100. With PACKET_FOLD_SAT_EN: 255,0,100.
4. Ping-pong: three 4-word packets sent back-to-back with m_tready=1 -> s_tready=0 only while both banks are FULL or DRAINING; outputs contiguous with no bubble between packets.
5. Backpressure: random m_tready (50%) on the case 1 packet -> identical data and order; m_* held stable whenever m_tvalid && !m_tready.
6. DEPTH=4, 6-word packet 1..6 with K=1 -> ovf pulse on tlast; output 5,2,3,4 with tlast on 4th beat. Reset asserted mid-packet -> no output, s_tready=0 during reset and 1 on the next cycle.
